// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl
//   Instruction-fetch sequencer for a single-issue core. It requests the word
//   at CurrentPC, waits for the read data, and presents it to the datapath.
//   When the datapath signals completion, it advances the PC by 4 or by the
//   resolved branch offset. Misaligned branch targets and read timeouts lock
//   the controller in FAULT; a halt request at completion locks it in HALT.
//
// Parameters
//   RESET_PC     PC value loaded on reset
//   TIMEOUT      maximum cycles spent in WAIT before FAULT
//
// Ports
//   CLK, resetl                 clock, asynchronous active-low reset
//   imem_req/imem_addr          fetch request and address (= CurrentPC)
//   imem_ready                  memory accepts the request
//   imem_rvalid/imem_rdata      returned instruction word
//   Instruction/inst_valid      latched word, one-cycle pulse on a new word
//   CurrentPC                   architectural PC
//   exec_done                   datapath finished; branch inputs valid
//   Branch/ALUZero/Uncondbranch branch resolution
//   SignExtImm64                byte-scaled branch offset
//   halt                        stop after the current instruction
//   halted/fault                sticky terminal-state indicators
module pc_fetch_ctrl #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter logic [7:0]  TIMEOUT  = 8'd64
) (
    input  logic        CLK,
    input  logic        resetl,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instruction,
    output logic        inst_valid,
    output logic [63:0] CurrentPC,
    input  logic        exec_done,
    input  logic        Branch,
    input  logic        ALUZero,
    input  logic        Uncondbranch,
    input  logic [63:0] SignExtImm64,
    input  logic        halt,
    output logic        halted,
    output logic        fault
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_EXEC,
        ST_HALT,
        ST_FAULT
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  wait_cnt;
    logic        new_word;
    logic        taken;
    logic [63:0] next_pc;
    logic        misaligned;
    logic        timeout_hit;

    // Branch resolution; only a taken branch can produce a misaligned target.
    assign taken       = Uncondbranch | (Branch & ALUZero);
    assign next_pc     = taken ? (CurrentPC + SignExtImm64) : (CurrentPC + 64'd4);
    assign misaligned  = taken && (next_pc[1:0] != 2'b00);
    // Last permitted WAIT cycle: an empty cycle here means TIMEOUT empty cycles.
    assign timeout_hit = (wait_cnt == (TIMEOUT - 8'd1));

    // State register
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: state_nxt = ST_REQ;
            ST_REQ: begin
                if (imem_ready) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // Data arriving in the timeout cycle still wins.
                if (imem_rvalid)      state_nxt = ST_EXEC;
                else if (timeout_hit) state_nxt = ST_FAULT;
            end
            ST_EXEC: begin
                if (exec_done) begin
                    if (misaligned) state_nxt = ST_FAULT;
                    else if (halt)  state_nxt = ST_HALT;
                    else            state_nxt = ST_REQ;
                end
            end
            ST_HALT:  state_nxt = ST_HALT;
            ST_FAULT: state_nxt = ST_FAULT;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        imem_req   = (state == ST_REQ);
        imem_addr  = CurrentPC;
        inst_valid = new_word && (state == ST_EXEC);
        halted     = (state == ST_HALT);
        fault      = (state == ST_FAULT);
    end

    // Datapath registers: PC, instruction latch, wait counter, new-word flag
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            CurrentPC   <= RESET_PC;
            Instruction <= '0;
            wait_cnt    <= '0;
            new_word    <= 1'b0;
        end else begin
            new_word <= (state == ST_WAIT) && imem_rvalid;
            case (state)
                ST_REQ: begin
                    if (imem_ready) wait_cnt <= '0;
                end
                ST_WAIT: begin
                    if (imem_rvalid) Instruction <= imem_rdata;
                    else             wait_cnt    <= wait_cnt + 8'd1;
                end
                ST_EXEC: begin
                    if (exec_done && !misaligned) CurrentPC <= next_pc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Testbench for pc_fetch_ctrl: directed vectors followed by randomized
// instruction transactions. Expected PC/instruction/status values come from a
// transaction-level model (expected PC plus last fetched word).
module tb_pc_fetch_ctrl;

    localparam logic [63:0] RST_PC = 64'h0;
    localparam logic [7:0]  TMO    = 8'd8;

    logic        CLK;
    logic        resetl;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] Instruction;
    logic        inst_valid;
    logic [63:0] CurrentPC;
    logic        exec_done;
    logic        Branch;
    logic        ALUZero;
    logic        Uncondbranch;
    logic [63:0] SignExtImm64;
    logic        halt;
    logic        halted;
    logic        fault;

    pc_fetch_ctrl #(
        .RESET_PC (RST_PC),
        .TIMEOUT  (TMO)
    ) dut (
        .CLK          (CLK),
        .resetl       (resetl),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .Instruction  (Instruction),
        .inst_valid   (inst_valid),
        .CurrentPC    (CurrentPC),
        .exec_done    (exec_done),
        .Branch       (Branch),
        .ALUZero      (ALUZero),
        .Uncondbranch (Uncondbranch),
        .SignExtImm64 (SignExtImm64),
        .halt         (halt),
        .halted       (halted),
        .fault        (fault)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    // Model: expected PC and last delivered instruction word
    logic [63:0] m_pc;
    logic [31:0] m_instr;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs;
        imem_ready   = 1'b0;
        imem_rvalid  = 1'b0;
        imem_rdata   = '0;
        exec_done    = 1'b0;
        Branch       = 1'b0;
        ALUZero      = 1'b0;
        Uncondbranch = 1'b0;
        SignExtImm64 = '0;
        halt         = 1'b0;
    endtask

    // Drive inputs the current state must ignore
    task automatic noise(input bit rv, input bit ex);
        imem_rvalid  = rv ? 1'($urandom_range(0, 1)) : 1'b0;
        imem_rdata   = $urandom;
        exec_done    = ex ? 1'($urandom_range(0, 1)) : 1'b0;
        halt         = 1'($urandom_range(0, 1));
        Branch       = 1'($urandom_range(0, 1));
        ALUZero      = 1'($urandom_range(0, 1));
        Uncondbranch = 1'($urandom_range(0, 1));
        SignExtImm64 = {$urandom, $urandom};
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req"},    64'(imem_req), 64'd0);
        check({tag, "_pc"},     CurrentPC, RST_PC);
        check({tag, "_addr"},   imem_addr, RST_PC);
        check({tag, "_instr"},  64'(Instruction), 64'd0);
        check({tag, "_ivalid"}, 64'(inst_valid), 64'd0);
        check({tag, "_halted"}, 64'(halted), 64'd0);
        check({tag, "_fault"},  64'(fault), 64'd0);
    endtask

    // Assert reset off-edge, check it acts immediately, release, step through IDLE.
    task automatic do_reset;
        idle_inputs();
        resetl = 1'b0;
        #2;
        check_reset_values("rst_async");
        tick();
        tick();
        check_reset_values("rst_hold");
        resetl  = 1'b1;
        m_pc    = RST_PC;
        m_instr = '0;
        #1;
        check("idle_noreq", 64'(imem_req), 64'd0);
        tick();
    endtask

    // One full instruction transaction, entered with the DUT in REQ.
    // outcome: 0 = next fetch, 1 = halted, 2 = faulted
    task automatic fetch_one(input int rdly, input int vdly, input int edly,
                             input logic [31:0] data, input bit br, input bit az,
                             input bit ub, input logic [63:0] imm, input bit hlt,
                             output int outcome);
        logic [63:0] tgt;
        bit          tk;
        check("req", 64'(imem_req), 64'd1);
        check("addr", imem_addr, m_pc);
        for (int i = 0; i < rdly; i++) begin
            noise(1'b1, 1'b1);
            imem_ready = 1'b0;
            tick();
            check("req_hold", 64'(imem_req), 64'd1);
            check("addr_hold", imem_addr, m_pc);
            check("instr_keep_req", 64'(Instruction), 64'(m_instr));
        end
        idle_inputs();
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        check("wait_noreq", 64'(imem_req), 64'd0);
        check("wait_noivalid", 64'(inst_valid), 64'd0);
        for (int i = 0; i < vdly; i++) begin
            noise(1'b0, 1'b1);
            tick();
            check("wait_nofault", 64'(fault), 64'd0);
            check("wait_noivalid", 64'(inst_valid), 64'd0);
            check("instr_keep_wait", 64'(Instruction), 64'(m_instr));
        end
        idle_inputs();
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        tick();
        m_instr = data;
        check("ivalid_pulse", 64'(inst_valid), 64'd1);
        check("instr", 64'(Instruction), 64'(m_instr));
        check("pc_exec", CurrentPC, m_pc);
        for (int i = 0; i < edly; i++) begin
            noise(1'b1, 1'b0);
            tick();
            check("ivalid_once", 64'(inst_valid), 64'd0);
            check("instr_keep_exec", 64'(Instruction), 64'(m_instr));
            check("pc_hold_exec", CurrentPC, m_pc);
        end
        idle_inputs();
        exec_done    = 1'b1;
        Branch       = br;
        ALUZero      = az;
        Uncondbranch = ub;
        SignExtImm64 = imm;
        halt         = hlt;
        tk  = ub || (br && az);
        tgt = tk ? m_pc + imm : m_pc + 64'd4;
        tick();
        idle_inputs();
        check("ivalid_after", 64'(inst_valid), 64'd0);
        if (tk && tgt[1:0] != 2'b00) begin
            outcome = 2;
            check("misalign_fault", 64'(fault), 64'd1);
            check("misalign_pc", CurrentPC, m_pc);
            check("misalign_noreq", 64'(imem_req), 64'd0);
        end else begin
            m_pc = tgt;
            check("pc_next", CurrentPC, m_pc);
            if (hlt) begin
                outcome = 1;
                check("halted", 64'(halted), 64'd1);
                check("halt_noreq", 64'(imem_req), 64'd0);
            end else begin
                outcome = 0;
                check("refetch_req", 64'(imem_req), 64'd1);
                check("refetch_addr", imem_addr, m_pc);
            end
        end
    endtask

    // Terminal states must hold regardless of inputs
    task automatic absorb(input int n, input bit eh, input bit ef);
        for (int i = 0; i < n; i++) begin
            noise(1'b1, 1'b1);
            imem_ready = 1'($urandom_range(0, 1));
            tick();
            check("abs_noreq", 64'(imem_req), 64'd0);
            check("abs_noivalid", 64'(inst_valid), 64'd0);
            check("abs_pc", CurrentPC, m_pc);
            check("abs_halted", 64'(halted), 64'(eh));
            check("abs_fault", 64'(fault), 64'(ef));
        end
        idle_inputs();
    endtask

    // Accept a request, then starve it of read data: TMO empty cycles fault.
    task automatic timeout_run;
        check("to_req", 64'(imem_req), 64'd1);
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        for (int i = 0; i < int'(TMO) - 1; i++) begin
            noise(1'b0, 1'b1);
            tick();
            check("to_notyet", 64'(fault), 64'd0);
        end
        noise(1'b0, 1'b1);
        tick();
        idle_inputs();
        check("to_fault", 64'(fault), 64'd1);
        check("to_noreq", 64'(imem_req), 64'd0);
    endtask

    // Reset in WAIT, with the stale response arriving after release
    task automatic wait_reset_run;
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        tick();
        resetl = 1'b0;
        #2;
        check_reset_values("wrst");
        tick();
        resetl      = 1'b1;
        m_pc        = RST_PC;
        m_instr     = '0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        check("wrst_instr0", 64'(Instruction), 64'd0);
        check("wrst_noivalid", 64'(inst_valid), 64'd0);
        tick();
        check("wrst_instr1", 64'(Instruction), 64'd0);
        check("wrst_req", 64'(imem_req), 64'd1);
        check("wrst_addr", imem_addr, RST_PC);
        idle_inputs();
    endtask

    initial begin
        int          oc;
        logic [63:0] imm;
        int          r;
        resetl = 1'b1;
        idle_inputs();
        m_pc    = RST_PC;
        m_instr = '0;
        #3;

        do_reset();
        fetch_one(0, 0, 0, 32'h8B02_0020, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, oc);
        check("v036_addr", imem_addr, 64'h4);
        check("v036_instr", 64'(Instruction), 64'h8B02_0020);
        fetch_one(0, 0, 0, $urandom, 1'b0, 1'b0, 1'b1, 64'hC, 1'b0, oc);
        check("v_addr10", imem_addr, 64'h10);
        fetch_one(1, 2, 1, $urandom, 1'b1, 1'b0, 1'b0, 64'h100, 1'b0, oc);
        check("v037_nottaken", imem_addr, 64'h14);
        fetch_one(0, 0, 0, $urandom, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, oc);
        fetch_one(0, 0, 0, $urandom, 1'b0, 1'b0, 1'b1, 64'h20, 1'b0, oc);
        check("v037_uncond", imem_addr, 64'h30);
        fetch_one(0, 0, 0, $urandom, 1'b0, 1'b0, 1'b1, 64'h10, 1'b0, oc);
        fetch_one(0, 0, 0, $urandom, 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, oc);
        check("v038_cond", imem_addr, 64'h38);
        fetch_one(0, 0, 0, $urandom, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC - 64'h38, 1'b0, oc);
        check("v_top", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        fetch_one(0, 0, 0, $urandom, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, oc);
        check("v038_wrap", imem_addr, 64'h0);
        fetch_one(5, int'(TMO) - 1, 2, $urandom, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, oc);
        check("v039_last_rvalid", imem_addr, 64'h4);
        fetch_one(0, 0, 0, $urandom, 1'b0, 1'b0, 1'b1, 64'h6, 1'b0, oc);
        check("v040_misalign_oc", 64'(oc), 64'd2);
        check("v040_pc_kept", CurrentPC, 64'h4);
        absorb(4, 1'b0, 1'b1);

        do_reset();
        fetch_one(0, 0, 0, $urandom, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, oc);
        fetch_one(0, 0, 0, $urandom, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, oc);
        fetch_one(0, 1, 0, $urandom, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1, oc);
        check("v040_halt_oc", 64'(oc), 64'd1);
        check("v040_halt_pc", CurrentPC, 64'hC);
        absorb(4, 1'b1, 1'b0);

        do_reset();
        timeout_run();
        absorb(3, 1'b0, 1'b1);

        do_reset();
        wait_reset_run();
        fetch_one(0, 0, 0, $urandom, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, oc);
        check("v041_restart", imem_addr, RST_PC + 64'd4);

        for (int n = 0; n < 250; n++) begin
            r = int'($urandom_range(0, 31));
            if (r == 0) begin
                timeout_run();
                absorb(2, 1'b0, 1'b1);
                do_reset();
            end else begin
                if (r == 1)      imm = {$urandom, $urandom};
                else if (r == 2) imm = 64'($urandom_range(0, 63)) * 64'd4 + 64'd2;
                else             imm = 64'($urandom_range(0, 255)) * 64'd4 - 64'd512;
                fetch_one(int'($urandom_range(0, 3)), int'($urandom_range(0, int'(TMO) - 1)),
                          int'($urandom_range(0, 3)), $urandom,
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), imm,
                          ($urandom_range(0, 24) == 0), oc);
                if (oc != 0) begin
                    absorb(2, oc == 1, oc == 2);
                    do_reset();
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, 64'h0, PC value loaded on reset.
REQ-002 Parameter TIMEOUT, 8'd64, maximum cycles spent in WAIT before fault.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 resetl  input  1  asynchronous, active-low reset.
REQ-005 imem_req  output  1  instruction fetch request valid.
REQ-006 imem_addr  output  64  fetch address, equal to CurrentPC.
REQ-007 imem_ready  input  1  memory accepts request (handshake with imem_req).
REQ-008 imem_rvalid  input  1  read data valid.
REQ-009 imem_rdata  input  32  fetched instruction word.
REQ-010 Instruction  output  32  latched instruction for datapath.
REQ-011 inst_valid  output  1  one-cycle pulse, new Instruction available.
REQ-012 CurrentPC  output  64  architectural PC.
REQ-013 exec_done  input  1  datapath finished current instruction; branch inputs valid this cycle.
REQ-014 Branch, ALUZero, Uncondbranch  input  1 each  branch resolution from control/ALU.
REQ-015 SignExtImm64  input  64  branch offset, already byte-scaled.
REQ-016 halt  input  1  stop after current instruction.
REQ-017 halted  output  1  sticky, controller in HALT.
REQ-018 fault  output  1  sticky, controller in FAULT.

Function
REQ-019 FSM states SHALL be IDLE, REQ, WAIT, EXEC, HALT, FAULT.
REQ-020 IDLE: one cycle after reset release, then REQ unconditionally.
REQ-021 REQ: imem_req=1; on imem_req&&imem_ready go WAIT, clear timeout counter; imem_req held until accepted.
REQ-022 WAIT: imem_req=0; imem_rvalid latches imem_rdata into Instruction, go EXEC; counter increments each cycle without rvalid.
REQ-023 WAIT with counter reaching TIMEOUT and no rvalid in that cycle -> FAULT; rvalid in the same cycle wins.
REQ-024 imem_rvalid outside WAIT SHALL be ignored (no latch, no state change).
REQ-025 inst_valid SHALL pulse exactly in the first EXEC cycle of each instruction.
REQ-026 EXEC: wait for exec_done; exec_done in the inst_valid cycle is legal (single-cycle execute).
REQ-027 On exec_done: CurrentPC <= CurrentPC + SignExtImm64 if Uncondbranch || (Branch && ALUZero), else CurrentPC + 4; arithmetic modulo 2^64, wrap silent.
REQ-028 Branch target with bits [1:0] != 0 -> PC unchanged, go FAULT.
REQ-029 exec_done && halt (aligned target) -> PC updated, go HALT; otherwise go REQ.
REQ-030 halt outside exec_done cycle SHALL be ignored.
REQ-031 HALT and FAULT absorbing until reset; no imem_req, no inst_valid; halted=1 in HALT, fault=1 in FAULT.
REQ-032 exec_done outside EXEC SHALL be ignored.
REQ-033 Fetch-to-fetch minimum: REQ(accept) -> WAIT(rvalid) -> EXEC(exec_done) -> REQ = 3 cycles per instruction.

Reset
REQ-034 resetl low SHALL immediately force state IDLE, CurrentPC=RESET_PC, Instruction=0, imem_req=0, inst_valid=0, halted=0, fault=0, counter=0.
REQ-035 Reset asserted mid-handshake (REQ/WAIT/EXEC) SHALL abandon the transaction; a late rvalid after release is ignored per REQ-024.

Verification
REQ-036 Reset release, ready=1, rvalid next cycle, rdata=32'h8B020020, exec_done in EXEC, no branch -> imem_addr 0 then 4, inst_valid one pulse, Instruction=32'h8B020020.
REQ-037 PC=0x10, Uncondbranch=1, SignExtImm64=0x20 at exec_done -> next imem_addr=0x30; Branch=1, ALUZero=0, Uncondbranch=0 -> 0x14.
REQ-038 PC=0x40, Branch=1, ALUZero=1, SignExtImm64=-8 -> 0x38; PC=64'hFFFF_FFFF_FFFF_FFFC, no branch -> 0x0.
REQ-039 imem_ready low 5 cycles -> imem_req held 5+1 cycles, addr stable; rvalid absent TIMEOUT cycles -> fault=1, imem_req stays 0.
REQ-040 SignExtImm64=0x6 taken branch -> fault=1, PC unchanged; halt with exec_done at PC=0x8 -> halted=1, CurrentPC=0xC, no further imem_req.
REQ-041 resetl pulsed low while in WAIT, rvalid arriving 1 cycle after release -> ignored, fetch restarts at RESET_PC.
